fft_pingpong_ram: RTL and testbench

//  Parametrised double-buffered (ping-pong) frame RAM for the FFT pipeline.
//  - Writes a continuous sample stream into one bank while the previous frame
//    is read from the other bank; banks swap every 2^LOGN samples.
//  - Read order is natural or bit-reversed, so the block serves as the

---
 rtl/fft_pingpong_ram.sv | 145 ++++++++++++++
 tb/tb_fft_pingpong_ram.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pingpong_ram.sv
// Double-buffered frame RAM: one bank fills from the sample stream while the
// other bank is read back in natural or bit-reversed order.
module fft_pingpong_ram #(
  parameter int unsigned NB     = 16,
  parameter int unsigned LOGN   = 6,
  parameter bit          BITREV = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          ED,
  input  logic          START,
  input  logic [NB-1:0] DI,
  output logic [NB-1:0] DO,
  output logic          DV,
  output logic          RDY
);

  localparam int unsigned N    = 2 ** LOGN;
  localparam int unsigned AW   = LOGN + 1;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LOGN-1:0] wcnt;
  logic            wbank;
  logic [LOGN-1:0] rcnt;
  logic            rd_act;
  logic [LOGN-1:0] raddr;
  logic            rbank;
  logic            rv1;
  logic            rf1;

  logic            wr_en_c;
  logic            swap_c;
  logic [LOGN-1:0] waddr_c;
  logic [LOGN-1:0] rcnt_br_c;

  logic [NB-1:0] mem [2*N];

  // Write-side control: a START always restarts the frame at address 0.
  always_comb begin
    state_nxt = state;
    wr_en_c   = 1'b0;
    swap_c    = 1'b0;
    waddr_c   = wcnt;
    if (START) begin
      state_nxt = S_WRITE;
      wr_en_c   = 1'b1;
      waddr_c   = '0;
    end else if (state == S_WRITE) begin
      wr_en_c   = 1'b1;
      swap_c    = (wcnt == LAST);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else if (ED) begin
      state <= state_nxt;
    end
  end

  // Write counter and bank select; the bank flips when a frame completes.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (ED && wr_en_c) begin
      if (swap_c) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt  <= waddr_c + LOGN'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ED && wr_en_c) begin
      mem[AW'({wbank, waddr_c})] <= DI;
    end
  end

  always_comb begin
    rcnt_br_c = '0;
    for (int i = 0; i < int'(LOGN); i++) begin
      rcnt_br_c[i] = rcnt[int'(LOGN) - 1 - i];
    end
  end

  // Read counter: a swap on the last read reloads with no bubble.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rcnt   <= '0;
      rd_act <= 1'b0;
    end else if (ED) begin
      if (swap_c) begin
        rcnt   <= '0;
        rd_act <= 1'b1;
      end else if (rd_act) begin
        if (rcnt == LAST) begin
          rcnt   <= '0;
          rd_act <= 1'b0;
        end else begin
          rcnt   <= rcnt + LOGN'(1);
        end
      end
    end
  end

  // The read bank travels with raddr so a swap cannot disturb the last read.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      raddr <= '0;
      rbank <= 1'b0;
      rv1   <= 1'b0;
      rf1   <= 1'b0;
    end else if (ED) begin
      raddr <= BITREV ? rcnt_br_c : rcnt;
      rbank <= ~wbank;
      rv1   <= rd_act;
      rf1   <= rd_act && (rcnt == '0);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DO  <= '0;
      DV  <= 1'b0;
      RDY <= 1'b0;
    end else if (ED) begin
      DO  <= mem[AW'({rbank, raddr})];
      DV  <= rv1;
      RDY <= rf1;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: bit-reversed and natural-order instances share
// one stimulus stream; expected outputs are queued per frame by a small model.
module tb_fft_pingpong_ram;

  localparam int N = 64;

  logic        CLK;
  logic        RSTN;
  logic        ED;
  logic        START;
  logic [15:0] DI;
  logic [15:0] do_o  [2];
  logic        dv_o  [2];
  logic        rdy_o [2];

  fft_pingpong_ram #(.NB(16), .LOGN(6), .BITREV(1'b1)) dut_br (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .DI(DI),
    .DO(do_o[0]), .DV(dv_o[0]), .RDY(rdy_o[0])
  );

  fft_pingpong_ram #(.NB(16), .LOGN(6), .BITREV(1'b0)) dut_nat (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .DI(DI),
    .DO(do_o[1]), .DV(dv_o[1]), .RDY(rdy_o[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        rdy;
    int          edge_n;
  } exp_t;

  typedef struct {
    logic        rstn;
    logic        ed;
    logic        start;
    logic [15:0] di;
    logic        chk_do;
    logic [15:0] exp_do;
    logic        exp_dv;
    logic        exp_rdy;
  } vec_t;

  int          total;
  int          bad;
  int          ecount;
  int          wc;
  int          e0;
  bit          started;
  logic [15:0] mbuf [N];
  exp_t        sbq [2][$];
  logic [15:0] prev_do  [2];
  logic        prev_dv  [2];
  logic        prev_rdy [2];
  int          vcnt   [2];
  int          rdycnt [2];

  function automatic int brev(input int p);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (p[b]) r = r | (1 << (5 - b));
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      sbq[i].delete();
      prev_do[i]  = '0;
      prev_dv[i]  = 1'b0;
      prev_rdy[i] = 1'b0;
      vcnt[i]     = 0;
      rdycnt[i]   = 0;
    end
    started = 1'b0;
    wc      = 0;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int p = 0; p < N; p++) begin
      e.rdy    = (p == 0);
      e.edge_n = e0 + N + 1 + p;
      e.data   = mbuf[brev(p)];
      sbq[0].push_back(e);
      e.data   = mbuf[p];
      sbq[1].push_back(e);
    end
  endtask

  task automatic model_write(input logic st, input logic [15:0] d);
    if (st) begin
      mbuf[0] = d;
      wc      = 1;
      e0      = ecount;
      started = 1'b1;
    end else if (started) begin
      if (wc == 0) e0 = ecount;
      mbuf[wc] = d;
      if (wc == N - 1) begin
        push_frame();
        wc = 0;
      end else begin
        wc++;
      end
    end
  endtask

  task automatic check_out();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (sbq[i].size() > 0 && sbq[i][0].edge_n == ecount) begin
        e = sbq[i].pop_front();
        if (dv_o[i] !== 1'b1 || do_o[i] !== e.data || rdy_o[i] !== e.rdy) begin
          bad++;
          $display("FAIL out%0d edge=%0d got dv=%0b do=%0d rdy=%0b want dv=1 do=%0d rdy=%0b",
                   i, ecount, dv_o[i], do_o[i], rdy_o[i], e.data, e.rdy);
        end
      end else if (dv_o[i] !== 1'b0 || rdy_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL idle%0d edge=%0d got dv=%0b rdy=%0b want dv=0 rdy=0",
                 i, ecount, dv_o[i], rdy_o[i]);
      end
      if (dv_o[i] === 1'b1) vcnt[i]++;
      if (rdy_o[i] === 1'b1) rdycnt[i]++;
      prev_do[i]  = do_o[i];
      prev_dv[i]  = dv_o[i];
      prev_rdy[i] = rdy_o[i];
    end
  endtask

  task automatic check_hold();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (do_o[i] !== prev_do[i] || dv_o[i] !== prev_dv[i] || rdy_o[i] !== prev_rdy[i]) begin
        bad++;
        $display("FAIL hold%0d got do=%0d dv=%0b rdy=%0b want do=%0d dv=%0b rdy=%0b",
                 i, do_o[i], dv_o[i], rdy_o[i], prev_do[i], prev_dv[i], prev_rdy[i]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (do_o[i] !== 16'd0 || dv_o[i] !== 1'b0 || rdy_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL %s%0d got do=%0d dv=%0b rdy=%0b want do=0 dv=0 rdy=0",
                 tag, i, do_o[i], dv_o[i], rdy_o[i]);
      end
    end
  endtask

  task automatic check_counts(input string tag, input int exp_v, input int exp_r);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (vcnt[i] != exp_v || rdycnt[i] != exp_r) begin
        bad++;
        $display("FAIL %s%0d got valid=%0d rdy=%0d want valid=%0d rdy=%0d",
                 tag, i, vcnt[i], rdycnt[i], exp_v, exp_r);
      end
    end
  endtask

  task automatic step(input logic ed, input logic st, input logic [15:0] d);
    @(negedge CLK);
    ED = ed; START = st; DI = d;
    @(posedge CLK);
    #1;
    if (ed) begin
      ecount++;
      model_write(st, d);
      check_out();
    end else begin
      check_hold();
    end
  endtask

  // Feeds count samples base.. starting with START; rnd gives 50% ED.
  task automatic feed(input int base, input int count, input bit rnd);
    int   idx;
    int   guard;
    logic ed;
    idx = 0; guard = 0;
    while (idx < count && guard < 5000) begin
      ed = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      step(ed, (idx == 0), 16'(base + idx));
      if (ed) idx++;
      guard++;
    end
    if (idx < count) begin
      total++; bad++;
      $display("FAIL feed_budget got=%0d want=%0d", idx, count);
    end
  endtask

  task automatic drain(input int n, input bit rnd);
    int   k;
    int   guard;
    logic ed;
    k = 0; guard = 0;
    while (k < n && guard < 5000) begin
      ed = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      step(ed, 1'b0, 16'($urandom));
      if (ed) k++;
      guard++;
    end
    if (k < n) begin
      total++; bad++;
      $display("FAIL drain_budget got=%0d want=%0d", k, n);
    end
  endtask

  // Asynchronous reset applied between clock edges, held with ED toggling.
  task automatic async_reset();
    #2;
    RSTN = 1'b0;
    #1;
    check_zero("rst_async");
    reset_model();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      ED = ~ED; START = 1'b1; DI = 16'hA5A5;
      @(posedge CLK);
      #1;
      check_zero("rst_hold");
    end
    @(negedge CLK);
    RSTN = 1'b1; START = 1'b0; ED = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 16'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h3333, 1'b1, 16'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h4444, 1'b1, 16'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h5555, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h6666, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h7777, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h8888, 1'b0, 16'd0, 1'b0, 1'b0};

    total = 0; bad = 0; ecount = 0; e0 = 0;
    RSTN = 1'b0; ED = 1'b0; START = 1'b0; DI = '0;
    reset_model();

    // 1: reset values, then no output without START
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      RSTN = tbl[k].rstn; ED = tbl[k].ed; START = tbl[k].start; DI = tbl[k].di;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dv_o[i] !== tbl[k].exp_dv || rdy_o[i] !== tbl[k].exp_rdy ||
            (tbl[k].chk_do && do_o[i] !== tbl[k].exp_do)) begin
          bad++;
          $display("FAIL vec%0d_%0d got do=%0d dv=%0b rdy=%0b want do=%0d dv=%0b rdy=%0b",
                   k, i, do_o[i], dv_o[i], rdy_o[i], tbl[k].exp_do, tbl[k].exp_dv, tbl[k].exp_rdy);
        end
      end
    end
    for (int i = 0; i < 2; i++) prev_do[i] = do_o[i];
    for (int k = 0; k < 200; k++) step(1'b1, 1'b0, 16'($urandom));
    check_counts("idle_cnt", 0, 0);

    // 2: single ramp frame
    async_reset();
    feed(0, N, 1'b0);
    drain(N + 1, 1'b0);
    check_counts("ramp_cnt", N, 1);

    // 3: two back-to-back frames
    async_reset();
    feed(0, 2 * N, 1'b0);
    drain(N + 1, 1'b0);
    check_counts("b2b_cnt", 2 * N, 2);

    // 4: random enable
    async_reset();
    feed(0, N, 1'b1);
    drain(N + 1, 1'b1);
    check_counts("ed_cnt", N, 1);

    // 5: restart after 20 samples
    async_reset();
    feed(0, 20, 1'b0);
    feed(100, N, 1'b0);
    drain(N + 1, 1'b0);
    check_counts("restart_cnt", N, 1);

    // 6: reset mid-read, then a clean frame
    async_reset();
    feed(0, N, 1'b0);
    drain(32, 1'b0);
    check_counts("midread_cnt", 31, 1);
    async_reset();
    feed(200, N, 1'b0);
    drain(N + 1, 1'b0);
    check_counts("after_rst_cnt", N, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
